dm_responder: RTL and testbench

Data-memory responder for the multicycle RISC-V core. It services load and store requests from the core's memory stage over a valid/ready request channel and a valid/ready response channel. It holds a word-organised storage array and applies byte lanes, the size code, and sign/zero extension on the memory side. It replaces the single-cycle RAM so the control unit can tolerate wait states.

---
 rtl/dm_responder_pkg.sv | 24 ++
 rtl/dm_lane_align.sv | 40 ++++
 rtl/dm_responder.sv | 129 ++++++++++++
 tb/tb_dm_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM state
// encoding, the error response word and the request error check.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dm_state_e;

  localparam logic [1:0]  SZ_BYTE       = 2'd0;
  localparam logic [1:0]  SZ_HALF       = 2'd1;
  localparam logic [1:0]  SZ_WORD       = 2'd2;
  localparam logic [31:0] RESP_ERR_DATA = 32'h0;

  // Illegal size code, or an access not aligned to its own size.
  function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'd3)
         | ((size == SZ_HALF) & addr_lo[0])
         | ((size == SZ_WORD) & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering between right-aligned core data and a 32-bit memory word:
// merges store data into the old word and extracts/extends load data.
module dm_lane_align
  import dm_responder_pkg::*;
(
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        se_i,
  output logic [31:0] wr_word_o,
  output logic [31:0] rd_word_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = mem_word_i[{addr_lo_i, 3'b000} +: 8];
  assign rd_half = mem_word_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    wr_word_o = mem_word_i;
    case (size_i)
      SZ_BYTE: wr_word_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: wr_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: wr_word_o = wdata_i;
    endcase
  end

  // Word (and the illegal code, which the caller masks) pass through unextended.
  always_comb begin
    rd_word_o = mem_word_i;
    case (size_i)
      SZ_BYTE: rd_word_o = se_i ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      SZ_HALF: rd_word_o = se_i ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: rd_word_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready load/store service over a word array,
// optional post-reset clear, one-cycle ACCESS and a held RESP phase.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  dm_state_e         state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              wr_q, se_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;

  logic [31:0]       cur_word, merged_word, load_word;
  logic              acc_err, req_hs;

  assign req_ready  = (state_q == ST_IDLE) & ~rst_;
  assign req_hs     = req_valid & req_ready;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != ST_IDLE);

  assign cur_word = mem_q[addr_q[ADDR_W-1:2]];
  assign acc_err  = req_is_err(size_q, addr_q[1:0]);

  dm_lane_align u_lane_align (
    .mem_word_i (cur_word),
    .wdata_i    (wdata_q),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .se_i       (se_q),
    .wr_word_o  (merged_word),
    .rd_word_o  (load_word)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_idx   = addr_q[ADDR_W-1:2];
    mem_wdata = merged_word;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_cnt_q;
        mem_wdata = 32'h0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_hs) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        err_d   = acc_err;
        mem_we  = wr_q & ~acc_err;
        rdata_d = (acc_err | wr_q) ? RESP_ERR_DATA : load_word;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset landing on the ACCESS cycle must not commit the store.
    if (rst_) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= INIT_ZERO ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      se_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'd0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (req_hs) begin
        wr_q    <= req_write;
        se_q    <= req_se;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, backpressure and
// reset corner cases, then random traffic against a byte-array memory model.
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_;
  logic              req_valid, req_ready, req_write, req_se;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err, busy;
  logic [31:0]       resp_rdata;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_se     (req_se),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic        se;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  mem_m [256];
  logic [32:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Byte-addressed model: little-endian bytes, natural alignment required.
  function automatic void model_access(input logic write, input logic [7:0] addr,
                                       input logic [1:0] size, input logic se,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int nb;
    logic [31:0] v;
    nb    = 1 << size;
    err   = (size == 2'd3) || ((int'(addr) % nb) != 0);
    rdata = 32'h0;
    if (err) return;
    if (write) begin
      for (int i = 0; i < nb; i++) mem_m[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[int'(addr) + i]) << (8*i));
      if (se && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rdata = v;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h0;
  endfunction

  task automatic add_vec(input logic write, input logic [7:0] addr, input logic [1:0] size,
                         input logic se, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.write = write; v.addr = addr; v.size = size; v.se = se; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic reset_and_clear(input string name);
    int n;
    rst_ = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({name, " rst req_ready"}, 32'(req_ready), 32'h0);
    check({name, " rst resp_valid"}, 32'(resp_valid), 32'h0);
    check({name, " rst resp_rdata"}, resp_rdata, 32'h0);
    check({name, " rst resp_err"}, 32'(resp_err), 32'h0);
    check({name, " rst busy"}, 32'(busy), 32'h1);
    rst_ = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) timeout_fail({name, " clear done"});
    else begin
      check({name, " clear cycles"}, 32'(n), 32'd64);
      check({name, " idle busy"}, 32'(busy), 32'h0);
    end
    model_clear();
  endtask

  // Runs one transaction; stall > 0 holds resp_ready low that many cycles
  // while a competing request is presented.
  task automatic do_txn(input logic write, input logic [7:0] addr, input logic [1:0] size,
                        input logic se, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int stall, input string name);
    int k;
    logic [32:0] exp;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    resp_ready = (stall == 0);
    req_valid = 1'b1; req_write = write; req_addr = addr; req_size = size;
    req_se = se; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      timeout_fail({name, " req_ready"});
      req_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    exp = exp_q.pop_front();
    if (!resp_valid) begin
      timeout_fail({name, " resp_valid"});
      resp_ready = 1'b1;
      return;
    end
    check({name, " latency"}, 32'(k), 32'd2);
    check({name, " rdata"}, resp_rdata, exp[31:0]);
    check({name, " err"}, 32'(resp_err), 32'(exp[32]));
    if (stall > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_size = SZ_WORD;
      req_wdata = $urandom;
      repeat (stall) begin
        @(negedge clk);
        check({name, " stall valid"}, 32'(resp_valid), 32'h1);
        check({name, " stall rdata"}, resp_rdata, exp[31:0]);
        check({name, " stall err"}, 32'(resp_err), 32'(exp[32]));
        check({name, " stall req_ready"}, 32'(req_ready), 32'h0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, " resp drop"}, 32'(resp_valid), 32'h0);
    check({name, " back idle"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          sz_pick;
    logic [1:0]  sz;

    rst_ = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 2'd0;
    req_se = 1'b0; req_wdata = 32'h0; resp_ready = 1'b1;

    reset_and_clear("init");

    // write, addr, size, se, wdata, exp_rdata, exp_err
    add_vec(0, 8'h3C, SZ_WORD, 0, 32'h0,        32'h00000000, 0);
    add_vec(1, 8'h10, SZ_WORD, 0, 32'h8899AABB, 32'h00000000, 0);
    add_vec(0, 8'h12, SZ_BYTE, 1, 32'h0,        32'hFFFFFF99, 0);
    add_vec(0, 8'h13, SZ_BYTE, 0, 32'h0,        32'h00000088, 0);
    add_vec(0, 8'h10, SZ_HALF, 1, 32'h0,        32'hFFFFAABB, 0);
    add_vec(1, 8'h11, SZ_BYTE, 0, 32'hFFFFFF5A, 32'h00000000, 0);
    add_vec(0, 8'h10, SZ_WORD, 1, 32'h0,        32'h88995ABB, 0);
    add_vec(1, 8'h12, SZ_HALF, 0, 32'hFFFF1234, 32'h00000000, 0);
    add_vec(0, 8'h10, SZ_WORD, 0, 32'h0,        32'h12345ABB, 0);
    add_vec(1, 8'h11, SZ_HALF, 0, 32'h0000FFFF, 32'h00000000, 1);
    add_vec(0, 8'h10, SZ_WORD, 0, 32'h0,        32'h12345ABB, 0);
    add_vec(1, 8'h22, SZ_WORD, 0, 32'hFFFFFFFF, 32'h00000000, 1);
    add_vec(0, 8'h20, SZ_WORD, 0, 32'h0,        32'h00000000, 0);
    add_vec(1, 8'h20, 2'd3,    0, 32'hCAFEF00D, 32'h00000000, 1);
    add_vec(0, 8'h20, 2'd3,    1, 32'h0,        32'h00000000, 1);
    add_vec(0, 8'h20, SZ_WORD, 0, 32'h0,        32'h00000000, 0);
    add_vec(0, 8'h13, SZ_HALF, 1, 32'h0,        32'h00000000, 1);
    add_vec(0, 8'h12, SZ_HALF, 0, 32'h0,        32'h00001234, 0);
    add_vec(0, 8'h10, SZ_BYTE, 1, 32'h0,        32'hFFFFFFBB, 0);

    foreach (vecs[i]) begin
      model_access(vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].se, vecs[i].wdata, r, e);
      do_txn(vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].se, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, 0, $sformatf("vec%0d", i));
    end

    // Backpressure on a load, then the next request must still go through.
    do_txn(0, 8'h10, SZ_WORD, 0, 32'h0, 32'h12345ABB, 0, 5, "bp load");
    do_txn(0, 8'h12, SZ_BYTE, 0, 32'h0, 32'h00000034, 0, 0, "bp next");

    for (int i = 0; i < 150; i++) begin
      sz_pick = $urandom_range(0, 9);
      sz = (sz_pick < 3) ? SZ_BYTE : (sz_pick < 6) ? SZ_HALF : (sz_pick < 9) ? SZ_WORD : 2'd3;
      req_addr = 8'($urandom_range(0, 63));
      req_write = 1'($urandom_range(0, 1));
      req_se = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      model_access(req_write, req_addr, sz, req_se, req_wdata, r, e);
      do_txn(req_write, req_addr, sz, req_se, req_wdata, r, e,
             $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    // Put known data where CLEAR must wipe it, then reset during a store's ACCESS.
    do_txn(1, 8'h10, SZ_WORD, 0, 32'hA5A5A5A5, 32'h0, 0, 0, "pre rst store");
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h04; req_size = SZ_WORD;
    req_se = 1'b0; req_wdata = 32'hDEADBEEF;
    check("midrst req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_ = 1'b1;
    reset_and_clear("midrst");
    do_txn(0, 8'h04, SZ_WORD, 0, 32'h0, 32'h00000000, 0, 0, "post rst @04");
    do_txn(0, 8'h10, SZ_WORD, 0, 32'h0, 32'h00000000, 0, 0, "post rst @10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
